// File: rtl/decoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : decoder_pkg                                                    |
// | Brief     : Shared constants and helpers for the select decoder pipeline.  |
// |             onehot() decodes at maximum width; callers truncate.           |
// |             parity_ok() is used only when DEC_PARITY_EN is defined.        |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package decoder_pkg;

   localparam int DEF_IN_W  = 3;
   localparam int DEF_CNT_W = 16;

   // Widest select field the helpers support; decoders up to 256 outputs.
   localparam int MAX_IN_W  = 8;
   localparam int MAX_OUT_W = 1 << MAX_IN_W;

   // Binary to one-hot at maximum width. Narrower users zero-extend the
   // select and keep only the low OUT_W bits of the result.
   function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_IN_W-1:0] sel);
      return MAX_OUT_W'(1) << sel;
   endfunction

   // Odd-parity check. Zero-extension does not change the XOR result, so
   // callers may pass any narrower vector padded with zeros.
   function automatic logic parity_ok(input logic [MAX_IN_W+1:0] v);
      return ^v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_onehot.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : decoder_onehot                                                 |
// | Brief     : Combinational binary-to-one-hot decoder with enable.           |
// |             Output is all-zero when i_en is low. IN_W must not exceed      |
// |             decoder_pkg::MAX_IN_W.                                         |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module decoder_onehot
   import decoder_pkg::*;
#(
   parameter int IN_W = DEF_IN_W
)(
   input  logic [IN_W-1:0]          i_sel,
   input  logic                     i_en,
   output logic [(1<<IN_W)-1:0]     o_onehot
);

   localparam int OUT_W = 1 << IN_W;

   logic [MAX_IN_W-1:0] w_sel_ext;

   // Zero-extend the select to the helper's fixed input width.
   always_comb begin
      w_sel_ext             = '0;
      w_sel_ext[IN_W-1:0]   = i_sel;
   end

   assign o_onehot = i_en ? OUT_W'(onehot(w_sel_ext)) : '0;

endmodule
`default_nettype wire

// File: rtl/decoder_sel_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : decoder_sel_pipe                                               |
// | Brief     : Registered one-hot select decoder with valid/ready handshake,  |
// |             pulse (HOLD=0) or hold (HOLD=1) output mode and a wrapping     |
// |             counter of issued non-zero selects.                            |
// |             Optional macro DEC_PARITY_EN adds in_par and a sticky parity   |
// |             error flag; without it err is tied low.                        |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module decoder_sel_pipe
   import decoder_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int HOLD  = 0,
   parameter int CNT_W = DEF_CNT_W
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic [IN_W-1:0]          in_sel,
   input  logic                     in_en,
   input  logic                     in_valid,
   output logic                     in_ready,
`ifdef DEC_PARITY_EN
   input  logic                     in_par,
`endif
   output logic [(1<<IN_W)-1:0]     out_sel,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CNT_W-1:0]         dec_cnt,
   output logic                     err
);

   localparam int OUT_W = 1 << IN_W;

   logic [OUT_W-1:0]  w_dec;
   logic              w_accept;
   logic              w_bad;
   logic [OUT_W-1:0]  r_sel;
   logic              r_valid;
   logic [CNT_W-1:0]  r_cnt;

   decoder_onehot #(
      .IN_W      (IN_W)
   ) u_onehot (
      .i_sel     (in_sel),
      .i_en      (in_en),
      .o_onehot  (w_dec)
   );

   // Single-stage pipe: a slot frees up in the same cycle it drains.
   assign in_ready = ~clr & (~r_valid | out_ready);
   assign w_accept = in_valid & in_ready;

`ifdef DEC_PARITY_EN
   logic [MAX_IN_W+1:0] w_par_vec;
   logic                r_err;

   // Pad the parity word to the helper width; zero bits do not affect XOR.
   always_comb begin
      w_par_vec            = '0;
      w_par_vec[IN_W+1:0]  = {in_en, in_sel, in_par};
   end

   assign w_bad = ~parity_ok(w_par_vec);

   // Sticky error: set by any accepted bad-parity beat, cleared by clr/rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (clr) begin
         r_err <= 1'b0;
      end else if (w_accept && w_bad) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   assign w_bad = 1'b0;
   assign err   = 1'b0;
`endif

   // Output stage: clr dominates, then accept (which also covers drain+accept),
   // then a plain drain which clears out_sel only in pulse mode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sel   <= '0;
         r_valid <= 1'b0;
      end else if (clr) begin
         r_sel   <= '0;
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_sel   <= w_bad ? '0 : w_dec;
         r_valid <= 1'b1;
      end else if (r_valid && out_ready) begin
         r_valid <= 1'b0;
         if (HOLD == 0) begin
            r_sel <= '0;
         end
      end
   end

   // Issued-select counter: only enabled, parity-clean beats count; clr leaves it alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (!clr && w_accept && in_en && !w_bad) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign out_sel   = r_sel;
   assign out_valid = r_valid;
   assign dec_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decoder_sel_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_decoder_sel_pipe                                            |
// | Brief     : Directed self-checking bench for decoder_sel_pipe. Two DUTs    |
// |             share stimulus: u_pulse (HOLD=0, CNT_W=16) and u_hold          |
// |             (HOLD=1, CNT_W=3). DEC_PARITY_EN enables the parity scenario.  |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_decoder_sel_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic [2:0]  in_sel;
   logic        in_en;
   logic        in_valid;
   logic        out_ready;
   logic        par_bad;

   logic        p_in_ready, h_in_ready;
   logic [7:0]  p_out_sel,  h_out_sel;
   logic        p_out_valid, h_out_valid;
   logic [15:0] p_cnt;
   logic [2:0]  h_cnt;
   logic        p_err, h_err;

   int errors = 0;
   int checks = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

`ifdef DEC_PARITY_EN
   logic in_par;
   assign in_par = (~^{in_en, in_sel}) ^ par_bad;
`endif

   decoder_sel_pipe #(.IN_W(3), .HOLD(0), .CNT_W(16)) u_pulse (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .in_sel    (in_sel),
      .in_en     (in_en),
      .in_valid  (in_valid),
      .in_ready  (p_in_ready),
`ifdef DEC_PARITY_EN
      .in_par    (in_par),
`endif
      .out_sel   (p_out_sel),
      .out_valid (p_out_valid),
      .out_ready (out_ready),
      .dec_cnt   (p_cnt),
      .err       (p_err)
   );

   decoder_sel_pipe #(.IN_W(3), .HOLD(1), .CNT_W(3)) u_hold (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .in_sel    (in_sel),
      .in_en     (in_en),
      .in_valid  (in_valid),
      .in_ready  (h_in_ready),
`ifdef DEC_PARITY_EN
      .in_par    (in_par),
`endif
      .out_sel   (h_out_sel),
      .out_valid (h_out_valid),
      .out_ready (out_ready),
      .dec_cnt   (h_cnt),
      .err       (h_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1; clr = 1'b0; in_sel = '0; in_en = 1'b0; in_valid = 1'b0;
      out_ready = 1'b1; par_bad = 1'b0;
      step(); step();
      checks++; if (p_out_sel !== 8'h00) begin errors++; $display("FAIL reset_sel got %h want 00", p_out_sel); end
      checks++; if (p_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", p_out_valid); end
      checks++; if (p_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", p_cnt); end
      checks++; if (p_err !== 1'b0 || h_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b%b want 00", p_err, h_err); end
      #2 rst = 1'b0;
      step();
      checks++; if (p_in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", p_in_ready); end
   endtask

   task automatic test_pulse();
      in_sel = 3'd5; in_en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      step(); exp_cnt++;
      checks++; if (p_out_sel !== 8'h20) begin errors++; $display("FAIL pulse_sel got %h want 20", p_out_sel); end
      checks++; if (p_out_valid !== 1'b1) begin errors++; $display("FAIL pulse_valid got %b want 1", p_out_valid); end
      idle();
      checks++; if (p_out_sel !== 8'h00) begin errors++; $display("FAIL pulse_drain_sel got %h want 00", p_out_sel); end
      checks++; if (p_out_valid !== 1'b0) begin errors++; $display("FAIL pulse_drain_valid got %b want 0", p_out_valid); end
      checks++; if (p_cnt !== 16'd1) begin errors++; $display("FAIL pulse_cnt got %0d want 1", p_cnt); end
      checks++; if (h_out_sel !== 8'h20) begin errors++; $display("FAIL pulse_hold_sel got %h want 20", h_out_sel); end
   endtask

   task automatic test_hold();
      in_sel = 3'd2; in_en = 1'b1; in_valid = 1'b1;
      step(); exp_cnt++;
      checks++; if (h_out_sel !== 8'h04 || h_out_valid !== 1'b1) begin errors++; $display("FAIL hold_accept got %h/%b want 04/1", h_out_sel, h_out_valid); end
      idle();
      checks++; if (h_out_valid !== 1'b0) begin errors++; $display("FAIL hold_drain_valid got %b want 0", h_out_valid); end
      checks++; if (h_out_sel !== 8'h04) begin errors++; $display("FAIL hold_drain_sel got %h want 04", h_out_sel); end
      checks++; if (p_out_sel !== 8'h00) begin errors++; $display("FAIL hold_pulse_sel got %h want 00", p_out_sel); end
      in_sel = 3'd6; in_en = 1'b0; in_valid = 1'b1;
      step();
      checks++; if (h_out_sel !== 8'h00 || h_out_valid !== 1'b1) begin errors++; $display("FAIL hold_en0 got %h/%b want 00/1", h_out_sel, h_out_valid); end
      checks++; if (h_cnt !== 3'(exp_cnt) || p_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL hold_cnt got %0d/%0d want %0d", p_cnt, h_cnt, exp_cnt); end
      idle();
   endtask

   task automatic test_backpressure();
      in_sel = 3'd7; in_en = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      step(); exp_cnt++;
      checks++; if (p_out_sel !== 8'h80 || p_out_valid !== 1'b1) begin errors++; $display("FAIL bp_first got %h/%b want 80/1", p_out_sel, p_out_valid); end
      in_sel = 3'd1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (p_in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b want 0", i, p_in_ready); end
         checks++; if (p_out_sel !== 8'h80 || p_out_valid !== 1'b1) begin errors++; $display("FAIL bp_stable[%0d] got %h/%b want 80/1", i, p_out_sel, p_out_valid); end
         step();
      end
      checks++; if (p_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL bp_cnt_held got %0d want %0d", p_cnt, exp_cnt); end
      out_ready = 1'b1;
      #1;
      checks++; if (p_in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", p_in_ready); end
      step(); exp_cnt++;
      checks++; if (p_out_sel !== 8'h02 || p_out_valid !== 1'b1) begin errors++; $display("FAIL bp_next got %h/%b want 02/1", p_out_sel, p_out_valid); end
      idle();
   endtask

   task automatic test_stream();
      logic [7:0] exp_sel;
      out_ready = 1'b1; in_en = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_sel = 3'(i);
         step(); exp_cnt++;
         exp_sel = 8'b1 << i;
         checks++; if (p_out_sel !== exp_sel || p_out_valid !== 1'b1) begin errors++; $display("FAIL stream[%0d] got %h/%b want %h/1", i, p_out_sel, p_out_valid, exp_sel); end
      end
      idle();
      checks++; if (p_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL stream_cnt got %0d want %0d", p_cnt, exp_cnt); end
      checks++; if (h_cnt !== 3'(exp_cnt % 8)) begin errors++; $display("FAIL stream_wrap_cnt got %0d want %0d", h_cnt, exp_cnt % 8); end
   endtask

   task automatic test_rst_clr();
      in_sel = 3'd4; in_en = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      exp_cnt = 0;
      checks++; if (p_out_sel !== 8'h00 || p_out_valid !== 1'b0) begin errors++; $display("FAIL async_rst got %h/%b want 00/0", p_out_sel, p_out_valid); end
      checks++; if (p_cnt !== 16'd0 || h_cnt !== 3'd0) begin errors++; $display("FAIL async_rst_cnt got %0d/%0d want 0", p_cnt, h_cnt); end
      #2 rst = 1'b0;
      out_ready = 1'b1;
      in_sel = 3'd6; in_valid = 1'b1;
      step(); exp_cnt++;
      checks++; if (p_out_sel !== 8'h40) begin errors++; $display("FAIL post_rst_sel got %h want 40", p_out_sel); end
      clr = 1'b1; in_sel = 3'd3;
      #1;
      checks++; if (p_in_ready !== 1'b0) begin errors++; $display("FAIL clr_ready got %b want 0", p_in_ready); end
      step();
      checks++; if (p_out_sel !== 8'h00 || p_out_valid !== 1'b0 || h_out_sel !== 8'h00) begin errors++; $display("FAIL clr_out got %h/%b/%h want 00/0/00", p_out_sel, p_out_valid, h_out_sel); end
      checks++; if (p_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL clr_cnt got %0d want %0d", p_cnt, exp_cnt); end
      clr = 1'b0;
      step(); exp_cnt++;
      checks++; if (p_out_sel !== 8'h08 || p_out_valid !== 1'b1) begin errors++; $display("FAIL after_clr got %h/%b want 08/1", p_out_sel, p_out_valid); end
      checks++; if (p_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL after_clr_cnt got %0d want %0d", p_cnt, exp_cnt); end
      idle();
   endtask

`ifdef DEC_PARITY_EN
   task automatic test_parity();
      in_sel = 3'd3; in_en = 1'b1; in_valid = 1'b1; out_ready = 1'b1; par_bad = 1'b1;
      step();
      par_bad = 1'b0; in_valid = 1'b0;
      checks++; if (p_out_sel !== 8'h00 || p_out_valid !== 1'b1) begin errors++; $display("FAIL par_out got %h/%b want 00/1", p_out_sel, p_out_valid); end
      checks++; if (p_err !== 1'b1) begin errors++; $display("FAIL par_err got %b want 1", p_err); end
      checks++; if (p_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL par_cnt got %0d want %0d", p_cnt, exp_cnt); end
      step();
      checks++; if (p_err !== 1'b1) begin errors++; $display("FAIL par_sticky got %b want 1", p_err); end
      clr = 1'b1;
      step();
      clr = 1'b0;
      checks++; if (p_err !== 1'b0) begin errors++; $display("FAIL par_clr got %b want 0", p_err); end
   endtask
`else
   task automatic test_no_parity();
      in_sel = 3'd3; in_en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      step(); exp_cnt++;
      checks++; if (p_err !== 1'b0 || p_out_sel !== 8'h08) begin errors++; $display("FAIL noparity got %b/%h want 0/08", p_err, p_out_sel); end
      idle();
   endtask
`endif

   initial begin
      test_reset();
      test_pulse();
      test_hold();
      test_backpressure();
      test_stream();
      test_rst_clr();
`ifdef DEC_PARITY_EN
      test_parity();
`else
      test_no_parity();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
